// File: rtl/axi_adf4030_pkg.sv
// Shared types and register map for the up-bus initiator,
// its responder and the bench.
package axi_adf4030_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } state_t;

    localparam int DATA_WIDTH = 32;

    localparam logic [7:0] ADDR_VERSION      = 8'h00;
    localparam logic [7:0] ADDR_ID           = 8'h01;
    localparam logic [7:0] ADDR_SCRATCH      = 8'h02;
    localparam logic [7:0] ADDR_MAGIC        = 8'h03;
    localparam logic [7:0] ADDR_CONTROL      = 8'h04;
    localparam logic [7:0] ADDR_DEBUG        = 8'h05;
    localparam logic [7:0] ADDR_MANUAL_TRIG  = 8'h06;
    localparam logic [7:0] ADDR_CHANNEL_BASE = 8'h07;

endpackage

// File: rtl/axi_adf4030_up_initiator.sv
// Single-outstanding initiator for the up_wreq/up_rreq register bus
// with a bounded acknowledge timeout.
module axi_adf4030_up_initiator
    import axi_adf4030_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  up_clk,
    input  logic                  up_rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_rnw,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]           cmd_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic                  resp_rnw,
    output logic [31:0]           resp_rdata,
    output logic                  resp_timeout,
    output logic                  busy,
    output logic                  up_wreq,
    output logic [ADDR_WIDTH-1:0] up_waddr,
    output logic [31:0]           up_wdata,
    input  logic                  up_wack,
    output logic                  up_rreq,
    output logic [ADDR_WIDTH-1:0] up_raddr,
    input  logic [31:0]           up_rdata,
    input  logic                  up_rack
);

    localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST =
        CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                  r_state;
    state_t                  w_state;
    logic                    r_rnw;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [CNT_WIDTH-1:0]    r_cnt;
    logic                    r_resp_rnw;
    logic [DATA_WIDTH-1:0]   r_resp_rdata;
    logic                    r_resp_timeout;
    logic                    w_cmd_hs;
    logic                    w_ack;
    logic                    w_expired;
    logic                    w_done;

    always_ff @(posedge up_clk) begin
        if (up_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state;
        end
    end

    // Only the ack matching the latched command type counts.
    always_comb begin
        w_state   = r_state;
        w_ack     = r_rnw ? up_rack : up_wack;
        w_cmd_hs  = 1'b0;
        w_expired = 1'b0;
        w_done    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (cmd_valid) begin
                    w_cmd_hs = 1'b1;
                    w_state  = REQ;
                end
            end
            REQ: begin
                w_done  = w_ack;
                w_state = w_ack ? RESP : WAIT;
            end
            WAIT: begin
                w_expired = (r_cnt == CNT_LAST);
                if (w_ack || w_expired) begin
                    w_done  = 1'b1;
                    w_state = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    w_state = IDLE;
                end
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge up_clk) begin
        if (up_rst) begin
            r_rnw          <= 1'b0;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_cnt          <= '0;
            r_resp_rnw     <= 1'b0;
            r_resp_rdata   <= '0;
            r_resp_timeout <= 1'b0;
        end else begin
            if (w_cmd_hs) begin
                r_rnw   <= cmd_rnw;
                r_addr  <= cmd_addr;
                r_wdata <= cmd_wdata;
            end
            if (r_state == REQ) begin
                r_cnt <= '0;
            end else if (r_state == WAIT && !w_expired) begin
                r_cnt <= r_cnt + 1'b1;
            end
            // An ack in the expiry cycle still wins over the timeout.
            if (w_done) begin
                r_resp_rnw     <= r_rnw;
                r_resp_timeout <= !w_ack;
                r_resp_rdata   <= (w_ack && r_rnw) ? up_rdata : '0;
            end
        end
    end

    assign cmd_ready    = (r_state == IDLE) && !up_rst;
    assign busy         = (r_state != IDLE);
    assign resp_valid   = (r_state == RESP);
    assign resp_rnw     = r_resp_rnw;
    assign resp_rdata   = r_resp_rdata;
    assign resp_timeout = r_resp_timeout;
    assign up_wreq      = (r_state == REQ) && !r_rnw;
    assign up_rreq      = (r_state == REQ) && r_rnw;
    assign up_waddr     = r_addr;
    assign up_raddr     = r_addr;
    assign up_wdata     = r_wdata;

endmodule
